sti_dac_gen: RTL

Parametrised next-generation serial transmitter and pixel-memory writer. Accepts one input word per load and assembles a frame of 1..MAX_LEN bytes. Shifts the frame out serially, then writes the same bit stream as bytes to a pixel memory. Compared with the fixed 16-bit/4-byte design, it adds:
- Generic data width and memory depth.
- A pi_ready input handshake and a pixel_ready write back-pressure input.
- Latching of all word controls at load.
- Deterministic overflow and end-of-frame zero fill.

---
 rtl/sti_dac_gen_if.sv | 34 +++
 rtl/sti_dac_gen.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sti_dac_gen_if.sv
// Word-load / serial-out / pixel-write bus of sti_dac_gen.
interface sti_dac_gen_if #(
  parameter int DATA_W  = 16,
  parameter int MAX_LEN = 4,
  parameter int ADDR_W  = 8
);
  localparam int LEN_W = $clog2(MAX_LEN);

  logic              load;
  logic              pi_ready;
  logic [DATA_W-1:0] pi_data;
  logic [LEN_W-1:0]  pi_length;
  logic              pi_fill;
  logic              pi_msb;
  logic              pi_low;
  logic              pi_end;
  logic              so_data;
  logic              so_valid;
  logic              pixel_wr;
  logic              pixel_ready;
  logic [ADDR_W-1:0] pixel_addr;
  logic [7:0]        pixel_dataout;
  logic              pixel_finish;

  modport slave (
    input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, pixel_ready,
    output pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout, pixel_finish
  );

  modport master (
    output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, pixel_ready,
    input  pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout, pixel_finish
  );
endinterface

// File: rtl/sti_dac_gen.sv
// Serial transmitter + pixel-memory writer: one word per load is framed to
// 1..MAX_LEN bytes, shifted out serially, then written byte-wise to memory.
module sti_dac_gen #(
  parameter int DATA_W  = 16,
  parameter int MAX_LEN = 4,
  parameter int ADDR_W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  sti_dac_gen_if.slave  bus
);
  localparam int LEN_W = $clog2(MAX_LEN);
  localparam int FW    = 8 * MAX_LEN;
  localparam int CNT_W = $clog2(FW) + 1;

  typedef enum logic [2:0] {IDLE, SHIFT, PIXEL, ZERO, DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  len_q, byte_k, sel;
  logic              fill_q, msb_q, low_q, end_q;
  logic [1:0]        pre_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [FW-1:0]     sreg, pbuf, frame;
  logic [ADDR_W-1:0] addr;
  logic              finish;
  logic              tx_bit, last_bit, last_byte, at_top;
  int                w;

  // frame width in bits and per-cycle status flags
  always_comb begin
    w         = 8 * (int'(len_q) + 1);
    tx_bit    = msb_q ? sreg[FW-1] : sreg[0];
    last_bit  = (pre_cnt == 2'd0) && (int'(bit_cnt) == w - 1);
    last_byte = (byte_k == len_q);
    at_top    = &addr;
    sel       = len_q - byte_k;
  end

  // build the W-bit frame from the latched word; bits above W forced to zero
  always_comb begin
    frame = FW'(data_q);
    if (w < DATA_W) begin
      if (low_q) frame = frame >> (DATA_W - w);
    end else if (w > DATA_W) begin
      if (fill_q) frame = frame << (w - DATA_W);
    end
    frame = frame & ~({FW{1'b1}} << w);
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic; a commit at the top address always wins
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.load) state_nx = SHIFT;
      SHIFT: if (last_bit) state_nx = PIXEL;
      PIXEL: if (bus.pixel_ready) begin
               if (at_top)         state_nx = DONE;
               else if (last_byte) state_nx = end_q ? ZERO : IDLE;
             end
      ZERO:  if (bus.pixel_ready && at_top) state_nx = DONE;
      DONE:  state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs decoded from state and datapath registers
  always_comb begin
    bus.pi_ready      = (state == IDLE);
    bus.so_valid      = (state == SHIFT) && (pre_cnt == 2'd0);
    bus.so_data       = bus.so_valid & tx_bit;
    bus.pixel_wr      = (state == PIXEL) || (state == ZERO);
    bus.pixel_dataout = (state == PIXEL) ? pbuf[8*int'(sel) +: 8] : 8'h00;
    bus.pixel_addr    = addr;
    bus.pixel_finish  = finish;
  end

  // datapath: latch on load, two-cycle frame prep, shift, address/finish
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= '0;
      len_q   <= '0;
      fill_q  <= 1'b0;
      msb_q   <= 1'b0;
      low_q   <= 1'b0;
      end_q   <= 1'b0;
      pre_cnt <= '0;
      bit_cnt <= '0;
      byte_k  <= '0;
      sreg    <= '0;
      pbuf    <= '0;
      addr    <= '0;
      finish  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.load) begin
          data_q  <= bus.pi_data;
          len_q   <= bus.pi_length;
          fill_q  <= bus.pi_fill;
          msb_q   <= bus.pi_msb;
          low_q   <= bus.pi_low;
          end_q   <= bus.pi_end;
          pre_cnt <= 2'd2;
          bit_cnt <= '0;
          byte_k  <= '0;
        end
        SHIFT: begin
          if (pre_cnt != 2'd0) begin
            // MSB-first frames are left-aligned so the next bit is always sreg[FW-1]
            if (pre_cnt == 2'd2) sreg <= msb_q ? (frame << (FW - w)) : frame;
            pre_cnt <= pre_cnt - 2'd1;
          end else begin
            sreg    <= msb_q ? (sreg << 1) : (sreg >> 1);
            pbuf    <= {pbuf[FW-2:0], tx_bit};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PIXEL: if (bus.pixel_ready) begin
          if (at_top) finish <= 1'b1;
          else begin
            addr   <= addr + 1'b1;
            byte_k <= byte_k + 1'b1;
          end
        end
        ZERO: if (bus.pixel_ready) begin
          if (at_top) finish <= 1'b1;
          else        addr   <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
